foc_sample_initiator: RTL
=========================

// Module: foc_sample_initiator
// PURPOSE
// - Upstream initiator for the FOC core's valid/ready sample port and its PID-config write ports.
// - On each PWM-period tick, captures resolver angle, phase currents, target current and periodTop.
// - Presents the captured sample with valid, holding it until ready accepts it.
// - Queues host PID-gain writes and replays them only while the core is idle, so gains never change mid-iteration.
// PARAMETERS
// - D_WIDTH    16  data width of angle/current/periodTop/PID cfg words
// - CFG_DEPTH  4   PID write FIFO entries (power of 2, >=2)
// - CNT_WIDTH  8   width of overrun counter (saturating)
// PORTS
// - clk             in   1        single clock
// - rst             in   1        reset, asynchronous, active-high
// - tick            in   1        one-cycle PWM-period strobe; triggers sample capture
// - angle_s         in   D_WIDTH  resolver angle
// - currA_s/B_s/C_s in   D_WIDTH  signed phase currents
// - currT_s         in   D_WIDTH  signed target current from ECU
// - period_s        in   D_WIDTH  PWM period top
// - cfg_wen         in   1        host PID write strobe
// - cfg_sel         in   1        0 = d-axis PID, 1 = q-axis PID
// - cfg_addr        in   D_WIDTH  PID register address
// - cfg_data        in   D_WIDTH  PID register data
// - cfg_full        out  1        FIFO full; writes presented while full are dropped
// - angle_out, currA_out/B_out/C_out, currT_out, periodTop_out  out  D_WIDTH  sample payload to core
// - valid           out  1        payload valid
// - ready           in   1        core ready (high = idle, accepts)
// - pid_d_wen, pid_q_wen    out  1        one-cycle PID write strobes
// - pid_d_addr, pid_q_addr  out  D_WIDTH  PID write address
// - pid_d_data, pid_q_data  out  D_WIDTH  PID write data
// - iter_done       out  1        one-cycle pulse when ready returns high after an accepted sample
// - overrun_cnt     out  CNT_WIDTH  ticks dropped, saturating at all-ones
// BEHAVIOUR
// - Reset: all outputs 0, including valid, strobes, payload, overrun_cnt and iter_done; FIFO empty; state IDLE.
// - Transfer: occurs on the rising edge where valid && ready. valid drops the next cycle.
//   - Payload is stable while valid is high.
// - Core ready is registered: it reads 0 the cycle after a transfer and returns to 1 on completion.
// - States:
//   - IDLE:  tick captures inputs -> ISSUE (valid=1 next cycle). Otherwise, if FIFO non-empty and ready=1, pop one entry per cycle.
//   - ISSUE: valid=1. On transfer -> BUSY.
//   - BUSY:  wait for ready==1. Then pulse iter_done for 1 cycle -> IDLE.
// - Tick in ISSUE or BUSY: sample dropped, overrun_cnt++ (saturating); payload unchanged.
// - Tick in IDLE takes priority over a FIFO pop in the same cycle: no pop that cycle.
// - FIFO pop: drives pid_d_* (cfg_sel=0) or pid_q_* (cfg_sel=1) with wen high for exactly 1 cycle.
//   - Addr/data hold their last value afterwards.
//   - Never pops in ISSUE or BUSY.
// - Simultaneous push and pop: both occur; count unchanged. Push while full: ignored, even if a pop happens that cycle.
// - Pointers wrap modulo CFG_DEPTH. cfg_full = (count == CFG_DEPTH).
// - Latency: tick -> valid high = 1 cycle; ready high in BUSY -> iter_done = 1 cycle.
// - Reset mid-operation: valid drops immediately (async). Queued writes are lost; no partial strobe.
// CONFIGURATION
// - FOC_LATENCY_MON_EN defined:
//   - Adds output lat_max [15:0]: maximum cycles from transfer to ready-high, saturating, reset 0.
//   - Adds input lat_clr: clears lat_max to 0 synchronously.
// - Undefined: neither port exists; no counter logic.
// STRUCTURE
// - Package foc_if_pkg:
//   - state enum {IDLE, ISSUE, BUSY}
//   - typedef cfg_entry_t {sel, addr, data}
//   - typedef sample_t {angle, currA, currB, currC, currT, period}
// - One sub-module: foc_cfg_fifo (sync FIFO of cfg_entry_t; push/pop/full/empty).
// - FSM, capture registers and overrun counter stay in the top.
// TESTING
// - tick with angle_s=16'h1234, currA_s=100, ready=1:
//   - valid=1 next cycle with angle_out=16'h1234, currA_out=100.
//   - Core drops ready 1 cycle later.
//   - iter_done pulses 1 cycle after ready returns.
// - Hold ready=0 for 20 cycles while valid=1, inject tick at cycle 5:
//   - payload unchanged; overrun_cnt=1; transfer only when ready=1.
// - Push 4 cfg writes (sel 0,1,0,1) with ready=0, then a 5th:
//   - cfg_full=1; 5th dropped.
//   - After ready=1: 4 single-cycle strobes in order, alternating d/q, correct addr/data.
// - tick coincides with non-empty FIFO in IDLE:
//   - sample issued first; no PID strobe until iter_done; remaining entries drain after.
// - Assert rst during BUSY with 2 FIFO entries:
//   - valid, strobes and overrun_cnt = 0 immediately; no PID write after release.
// - 300 ticks while ready held 0: overrun_cnt saturates at 255.

Source files
------------

// File: rtl/foc_if_pkg.sv
// Shared types for the FOC sample initiator.
// Contents:
//   FOC_D_WIDTH : word width carried by the sample and config structs.
//   state_t     : initiator FSM states.
//   cfg_entry_t : one queued PID register write.
//   sample_t    : one captured sample for the core.
package foc_if_pkg;

  // Width of the struct fields. The top-level D_WIDTH parameter must match it.
  localparam int FOC_D_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  typedef struct packed {
    logic                   sel;   // 0 = d-axis PID, 1 = q-axis PID
    logic [FOC_D_WIDTH-1:0] addr;
    logic [FOC_D_WIDTH-1:0] data;
  } cfg_entry_t;

  typedef struct packed {
    logic [FOC_D_WIDTH-1:0] angle;
    logic [FOC_D_WIDTH-1:0] currA;
    logic [FOC_D_WIDTH-1:0] currB;
    logic [FOC_D_WIDTH-1:0] currC;
    logic [FOC_D_WIDTH-1:0] currT;
    logic [FOC_D_WIDTH-1:0] period;
  } sample_t;

endpackage

// File: rtl/foc_sample_initiator_if.sv
// Interface between the sample initiator and the FOC core.
// Carries the valid/ready sample port and both PID-config write ports.
//   master : initiator side (drives payload, valid, PID writes; reads ready)
//   slave  : core side
interface foc_sample_initiator_if #(
  parameter int D_WIDTH = 16
);
  logic [D_WIDTH-1:0] angle_out;
  logic [D_WIDTH-1:0] currA_out;
  logic [D_WIDTH-1:0] currB_out;
  logic [D_WIDTH-1:0] currC_out;
  logic [D_WIDTH-1:0] currT_out;
  logic [D_WIDTH-1:0] periodTop_out;
  logic               valid;
  logic               ready;
  logic               pid_d_wen;
  logic               pid_q_wen;
  logic [D_WIDTH-1:0] pid_d_addr;
  logic [D_WIDTH-1:0] pid_q_addr;
  logic [D_WIDTH-1:0] pid_d_data;
  logic [D_WIDTH-1:0] pid_q_data;

  modport master (
    output angle_out, currA_out, currB_out, currC_out, currT_out, periodTop_out,
    output valid,
    input  ready,
    output pid_d_wen, pid_q_wen, pid_d_addr, pid_q_addr, pid_d_data, pid_q_data
  );

  modport slave (
    input  angle_out, currA_out, currB_out, currC_out, currT_out, periodTop_out,
    input  valid,
    output ready,
    input  pid_d_wen, pid_q_wen, pid_d_addr, pid_q_addr, pid_d_data, pid_q_data
  );
endinterface

// File: rtl/foc_cfg_fifo.sv
// Synchronous FIFO of PID config writes.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_push, i_entry: write request and entry; ignored while full
//   i_pop          : read request; ignored while empty
//   o_head         : entry at the head (show-ahead, valid when !o_empty)
//   o_full/o_empty : occupancy flags
module foc_cfg_fifo
  import foc_if_pkg::*;
#(
  parameter int DEPTH = 4   // power of 2, >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  cfg_entry_t i_entry,
  input  logic       i_pop,
  output cfg_entry_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cfg_entry_t         r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // A full FIFO drops the push even when a pop frees a slot in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Power-of-2 depth: pointers wrap by natural overflow.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/foc_sample_initiator.sv
// Upstream initiator for the FOC core.
// Captures a sample on each PWM tick and offers it with valid/ready. It queues
// host PID-gain writes and replays them only while the core is idle.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   tick              : PWM-period strobe, captures the *_s inputs
//   angle_s .. period_s : sample inputs
//   cfg_wen/sel/addr/data : host PID write; cfg_full flags a full queue
//   core              : core-side bus (payload, valid, ready, PID writes)
//   iter_done         : one-cycle pulse when the core finishes a sample
//   overrun_cnt       : count of dropped ticks, saturating
// Build option FOC_LATENCY_MON_EN adds lat_clr (in) and lat_max[15:0] (out).
// lat_max holds the longest transfer-to-ready latency seen, in cycles.
module foc_sample_initiator
  import foc_if_pkg::*;
#(
  parameter int D_WIDTH   = 16,  // must equal FOC_D_WIDTH
  parameter int CFG_DEPTH = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [D_WIDTH-1:0]   angle_s,
  input  logic [D_WIDTH-1:0]   currA_s,
  input  logic [D_WIDTH-1:0]   currB_s,
  input  logic [D_WIDTH-1:0]   currC_s,
  input  logic [D_WIDTH-1:0]   currT_s,
  input  logic [D_WIDTH-1:0]   period_s,
  input  logic                 cfg_wen,
  input  logic                 cfg_sel,
  input  logic [D_WIDTH-1:0]   cfg_addr,
  input  logic [D_WIDTH-1:0]   cfg_data,
  output logic                 cfg_full,
  foc_sample_initiator_if.master core,
  output logic                 iter_done,
  output logic [CNT_WIDTH-1:0] overrun_cnt
`ifdef FOC_LATENCY_MON_EN
  ,
  input  logic                 lat_clr,
  output logic [15:0]          lat_max
`endif
);

  state_t               r_state, w_next_state;
  sample_t              r_sample;
  logic [CNT_WIDTH-1:0] r_overrun;
  logic                 r_iter_done;
  logic                 r_pid_d_wen, r_pid_q_wen;
  logic [D_WIDTH-1:0]   r_pid_d_addr, r_pid_d_data, r_pid_q_addr, r_pid_q_data;
  logic                 w_capture, w_overrun, w_pop, w_done;
  logic                 w_fifo_empty;
  cfg_entry_t           w_push_entry, w_head;

  assign w_push_entry = '{sel: cfg_sel, addr: cfg_addr, data: cfg_data};

  foc_cfg_fifo #(.DEPTH(CFG_DEPTH)) u_cfg_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cfg_wen),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (cfg_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_overrun    = 1'b0;
    w_pop        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        // A tick wins over a pending PID write in the same cycle.
        if (tick) begin
          w_capture    = 1'b1;
          w_next_state = ISSUE;
        end else if (!w_fifo_empty && core.ready) begin
          w_pop = 1'b1;
        end
      end
      ISSUE: begin
        w_overrun = tick;
        if (core.ready) w_next_state = BUSY;
      end
      BUSY: begin
        w_overrun = tick;
        if (core.ready) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sample     <= '0;
      r_overrun    <= '0;
      r_iter_done  <= 1'b0;
      r_pid_d_wen  <= 1'b0;
      r_pid_q_wen  <= 1'b0;
      r_pid_d_addr <= '0;
      r_pid_d_data <= '0;
      r_pid_q_addr <= '0;
      r_pid_q_data <= '0;
    end else begin
      r_state     <= w_next_state;
      r_iter_done <= w_done;
      if (w_capture) begin
        r_sample <= '{angle: angle_s, currA: currA_s, currB: currB_s,
                      currC: currC_s, currT: currT_s, period: period_s};
      end
      if (w_overrun && (r_overrun != {CNT_WIDTH{1'b1}})) r_overrun <= r_overrun + 1'b1;
      // Strobes last one cycle; addr/data keep the last written value.
      r_pid_d_wen <= w_pop && !w_head.sel;
      r_pid_q_wen <= w_pop &&  w_head.sel;
      if (w_pop && !w_head.sel) begin
        r_pid_d_addr <= w_head.addr;
        r_pid_d_data <= w_head.data;
      end
      if (w_pop && w_head.sel) begin
        r_pid_q_addr <= w_head.addr;
        r_pid_q_data <= w_head.data;
      end
    end
  end

  // valid decodes straight from the state register, so reset clears it at once.
  assign core.valid         = (r_state == ISSUE);
  assign core.angle_out     = r_sample.angle;
  assign core.currA_out     = r_sample.currA;
  assign core.currB_out     = r_sample.currB;
  assign core.currC_out     = r_sample.currC;
  assign core.currT_out     = r_sample.currT;
  assign core.periodTop_out = r_sample.period;
  assign core.pid_d_wen     = r_pid_d_wen;
  assign core.pid_q_wen     = r_pid_q_wen;
  assign core.pid_d_addr    = r_pid_d_addr;
  assign core.pid_d_data    = r_pid_d_data;
  assign core.pid_q_addr    = r_pid_q_addr;
  assign core.pid_q_data    = r_pid_q_data;
  assign iter_done          = r_iter_done;
  assign overrun_cnt        = r_overrun;

`ifdef FOC_LATENCY_MON_EN
  logic [15:0] r_lat_cnt, r_lat_max;

  // The count starts at 1 on the transfer edge. It stops at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_cnt <= '0;
      r_lat_max <= '0;
    end else begin
      if (r_state == ISSUE && core.ready) begin
        r_lat_cnt <= 16'd1;
      end else if (r_state == BUSY && !core.ready && r_lat_cnt != 16'hFFFF) begin
        r_lat_cnt <= r_lat_cnt + 1'b1;
      end
      if (lat_clr) begin
        r_lat_max <= '0;
      end else if (w_done && r_lat_cnt > r_lat_max) begin
        r_lat_max <= r_lat_cnt;
      end
    end
  end

  assign lat_max = r_lat_max;
`endif

endmodule
